sram_stream_reader: RTL
=======================

Name: sram_stream_reader

Overview:
- Read sequencer directly downstream of the 24-bit single-port SRAM buffer.
- On a start command it reads a contiguous block of words from the SRAM.
- It hides the SRAM's 1-cycle registered read latency and presents the words as a valid/ready stream to the next processing stage.
- It owns the SRAM port while busy and only reads (write enable is tied low).

Parameters:
- DATA_WIDTH, 24, SRAM word width.
- ADDR_WIDTH, 6, SRAM address width.
- RAM_SIZE, 36, number of valid SRAM entries; addresses wrap at this value.

Ports:
- clk  input  1  system clock, all state on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle command pulse; honoured only while idle.
- base_addr  input  ADDR_WIDTH  first SRAM address, sampled with start.
- length  input  ADDR_WIDTH+1  word count, sampled with start.
- busy  output  1  high from the cycle after an accepted start until done.
- done  output  1  one-cycle pulse when the final word is accepted downstream.
- sram_en  output  1  SRAM enable; high on every read-issue cycle.
- sram_we  output  1  constant 0.
- sram_addr  output  ADDR_WIDTH  SRAM read address.
- sram_rdata  input  DATA_WIDTH  SRAM data_o; valid the cycle after the read is issued.
- out_valid  output  1  stream data valid.
- out_ready  input  1  downstream ready.
- out_data  output  DATA_WIDTH  stream word.
- out_last  output  1  high with the final word of the block.

Behaviour:
- Reset (asynchronous, active-low): all outputs go to 0, the FSM goes to IDLE, and the buffer is cleared. Asserting reset mid-block aborts the block with no done pulse.
- FSM states: IDLE, READ, DRAIN, DONE.
- IDLE:
  - start with length==0: go to DONE directly (done pulses, no reads issued).
  - start with length>0: latch base_addr and the effective length, clamped to RAM_SIZE if larger; go to READ.
  - start while not IDLE is ignored.
- READ: issue a read (sram_en=1, sram_addr=current address) in any cycle where buffered words + in-flight reads < 2.
  - After each issue, the address increments. Address RAM_SIZE-1 wraps to 0.
  - After the last issue, go to DRAIN.
- Read capture: the cycle after an issue, sram_rdata is written into a 2-entry FIFO (the skid buffer).
  - out_data/out_valid come from the FIFO head.
  - A transfer occurs when out_valid && out_ready.
- DRAIN: wait until all words are transferred. When the last word transfers, go to DONE.
- DONE: done=1 for exactly one cycle, then return to IDLE. busy=0 in DONE.
- out_last is high only when the head word is word number length-1 of the block.
- Stream rule: out_data and out_last stay stable while out_valid && !out_ready.
- Latency and throughput:
  - Start accepted at cycle T: first read at T+1, out_valid at T+2.
  - With out_ready held high, one word per cycle.
  - A block of N words ends with done at T+N+2.
- Backpressure: with out_ready low, at most 2 words are buffered and no further reads issue; there is no data loss or duplication.
- Wrap-around example: base_addr=34, length=4 reads addresses 34, 35, 0, 1.

Optional Feature:
- Macro SRAM_RD_CHKSUM_EN.
- When defined:
  - Adds output chksum (DATA_WIDTH).
  - chksum is the modulo-2^DATA_WIDTH sum of all words transferred in the current block.
  - Cleared to 0 on an accepted start and on reset.
  - Final value is valid from the done pulse until the next accepted start.
- When undefined: the port and adder are absent; all other behaviour is identical.

Test Plan:
- Basic read: preload SRAM[i]=i+0x100, start base=0 length=4, out_ready=1 -> words 0x100..0x103 on consecutive cycles starting at T+2; out_last with 0x103; done at T+6.
- Wrap: base=34 length=4 -> addresses 34, 35, 0, 1 on sram_addr; data in that order; out_last on the 4th word.
- Backpressure: length=6, out_ready toggling 1,0,0,1,... -> all 6 words exactly once and in order; sram_en never issues while 2 words are buffered plus in flight; out_data stable while stalled.
- Zero length and clamp: start length=0 -> done one cycle later, sram_en never high. Start length=50 -> exactly 36 words transferred.
- Start ignored and reset abort: start pulsed while busy has no effect. reset_n low mid-block -> all outputs 0 immediately, no done pulse; a new start afterwards behaves normally.
- Checksum (SRAM_RD_CHKSUM_EN defined): words 1, 2, 0xFFFFFF -> chksum=0x000002 at done.

Source files
------------

// File: rtl/sram_stream_reader.sv
// sram_stream_reader: streams a block of SRAM words out over valid/ready.
// Optional feature macro: SRAM_RD_CHKSUM_EN (adds running block checksum).
module sram_stream_reader #(
    parameter int unsigned DATA_WIDTH = 24,
    parameter int unsigned ADDR_WIDTH = 6,
    parameter int unsigned RAM_SIZE   = 36
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   length,
    output logic                  busy,
    output logic                  done,
    output logic                  sram_en,
    output logic                  sram_we,
    output logic [ADDR_WIDTH-1:0] sram_addr,
    input  logic [DATA_WIDTH-1:0] sram_rdata,
`ifdef SRAM_RD_CHKSUM_EN
    output logic [DATA_WIDTH-1:0] chksum,
`endif
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last
);

    localparam int unsigned LEN_W = ADDR_WIDTH + 1;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        DRAIN,
        DONE
    } state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] addr;
    logic [ADDR_WIDTH-1:0] addr_next;
    logic [LEN_W-1:0]      issue_left;
    logic [LEN_W-1:0]      eff_len;

    logic                  inflight;
    logic                  inflight_last;
    logic [DATA_WIDTH-1:0] buf_data [2];
    logic [1:0]            buf_last;
    logic                  wr_ptr;
    logic                  rd_ptr;
    logic [1:0]            count;
    logic [1:0]            level;

    logic                  issue;
    logic                  fire;
    logic                  push;
    logic                  pop;
    logic                  head_buf;

    // Blocks longer than the SRAM are clamped to one full pass.
    assign eff_len   = (length > LEN_W'(RAM_SIZE)) ? LEN_W'(RAM_SIZE) : length;
    assign addr_next = (addr == ADDR_WIDTH'(RAM_SIZE - 1)) ? '0 : addr + 1'b1;

    // Words held plus the one returning from the SRAM never exceed two.
    assign level    = count + {1'b0, inflight};
    assign issue    = (state == READ) && (level < 2'd2);

    assign sram_en   = issue;
    assign sram_we   = 1'b0;
    assign sram_addr = addr;

    // Head is the oldest buffered word, else the word arriving from the SRAM.
    assign head_buf  = (count != 2'd0);
    assign out_valid = head_buf || inflight;
    assign out_data  = head_buf ? buf_data[rd_ptr]
                     : (inflight ? sram_rdata : '0);
    assign out_last  = head_buf ? buf_last[rd_ptr]
                     : (inflight && inflight_last);

    assign fire = out_valid && out_ready;
    assign push = inflight && !(!head_buf && fire);
    assign pop  = fire && head_buf;

    // Block sequencer: command accept, read issue, drain, done pulse.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            addr       <= '0;
            issue_left <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        if (length == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state      <= READ;
                            busy       <= 1'b1;
                            addr       <= base_addr;
                            issue_left <= eff_len;
                        end
                    end
                end
                READ: begin
                    if (issue) begin
                        addr       <= addr_next;
                        issue_left <= issue_left - 1'b1;
                        if (issue_left == LEN_W'(1)) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (fire && out_last) begin
                        state <= DONE;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Track the outstanding read and capture returning words into the skid buffer.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
            buf_data[0]   <= '0;
            buf_data[1]   <= '0;
            buf_last      <= '0;
            wr_ptr        <= 1'b0;
            rd_ptr        <= 1'b0;
            count         <= '0;
        end else begin
            inflight      <= issue;
            inflight_last <= issue && (issue_left == LEN_W'(1));
            if (push) begin
                buf_data[wr_ptr] <= sram_rdata;
                buf_last[wr_ptr] <= inflight_last;
                wr_ptr           <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            unique case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

`ifdef SRAM_RD_CHKSUM_EN
    // Running sum of every word handed downstream in the current block.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            chksum <= '0;
        end else if (state == IDLE && start) begin
            chksum <= '0;
        end else if (fire) begin
            chksum <= chksum + out_data;
        end
    end
`endif

endmodule
